// File: rtl/gradient_pkg.sv
// ---------------------------------------------------------------------------
// gradient_pkg: widths, kernel type and FSM encoding for gradient_convolver.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gradient_pkg;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 5;
  localparam int ACC_W  = 17;

  typedef logic [2:0][2:0][COEF_W-1:0] kernel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } conv_state_t;

  // Row-major pixel index to {row, col}
  function automatic logic [3:0] rc_of(input logic [3:0] idx);
    case (idx)
      4'd0:    rc_of = {2'd0, 2'd0};
      4'd1:    rc_of = {2'd0, 2'd1};
      4'd2:    rc_of = {2'd0, 2'd2};
      4'd3:    rc_of = {2'd1, 2'd0};
      4'd4:    rc_of = {2'd1, 2'd1};
      4'd5:    rc_of = {2'd1, 2'd2};
      4'd6:    rc_of = {2'd2, 2'd0};
      4'd7:    rc_of = {2'd2, 2'd1};
      4'd8:    rc_of = {2'd2, 2'd2};
      default: rc_of = 4'd0;
    endcase
  endfunction
endpackage

`default_nettype wire

// File: rtl/gradient_convolver_mac_lane.sv
// ---------------------------------------------------------------------------
// mac_lane: unsigned-pixel x signed-coefficient multiply with load/acc/clear.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_lane
  import gradient_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              acc,
  input  logic              clr,
  input  logic [PIX_W-1:0]  pixel,
  input  logic [COEF_W-1:0] coef,
  output logic [ACC_W-1:0]  sum,
  output logic [ACC_W-1:0]  sum_next
);
  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] coef_ext;
  logic signed [ACC_W-1:0] product;
  logic signed [ACC_W-1:0] acc_q;

  assign pix_ext  = $signed({{(ACC_W-PIX_W){1'b0}}, pixel});
  assign coef_ext = $signed({{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef});
  assign product  = pix_ext * coef_ext;

  // Next value is exported so the magnitude can be registered alongside it
  always_comb begin
    sum_next = acc_q;
    if (clr)       sum_next = '0;
    else if (load) sum_next = product;
    else if (acc)  sum_next = acc_q + product;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= sum_next;
  end

  assign sum = acc_q;
endmodule

`default_nettype wire

// File: rtl/gradient_convolver.sv
// ---------------------------------------------------------------------------
// gradient_convolver: serial 3x3 X/Y gradient MAC with saturated magnitude.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gradient_convolver
  import gradient_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0][2:0][COEF_W-1:0]  kx,
  input  logic [2:0][2:0][COEF_W-1:0]  ky,
  input  logic                         flush,
  input  logic [PIX_W-1:0]             pixel_in,
  input  logic                         pixel_valid,
  output logic                         pixel_ready,
  output logic [ACC_W-1:0]             gx_out,
  output logic [ACC_W-1:0]             gy_out,
  output logic [PIX_W-1:0]             mag_out,
  output logic                         result_valid,
  input  logic                         result_ready
);
  conv_state_t       state;
  logic [3:0]        cnt;
  kernel_t           kx_l;
  kernel_t           ky_l;
  logic              accept;
  logic              first;
  logic              more;
  logic [1:0]        row;
  logic [1:0]        col;
  logic [COEF_W-1:0] cx;
  logic [COEF_W-1:0] cy;
  logic [ACC_W-1:0]  gx_next;
  logic [ACC_W-1:0]  gy_next;
  logic [ACC_W:0]    abs_x;
  logic [ACC_W:0]    abs_y;
  logic [ACC_W:0]    mag_sum;
  logic [PIX_W-1:0]  mag_sat;

  assign pixel_ready = !rst && (state != RESULT);
  // Flush outranks a coincident accept, so the pixel is simply dropped
  assign accept      = pixel_valid && pixel_ready && !flush;
  assign first       = accept && (state == IDLE);
  assign more        = accept && (state == ACCUM);

  assign {row, col} = rc_of(cnt);
  // Pixel 0 uses the live kernel since it is latched on that same edge
  assign cx = (state == IDLE) ? kx[0][0] : kx_l[row][col];
  assign cy = (state == IDLE) ? ky[0][0] : ky_l[row][col];

  mac_lane u_lane_x (
    .clk      (clk),
    .rst      (rst),
    .load     (first),
    .acc      (more),
    .clr      (flush),
    .pixel    (pixel_in),
    .coef     (cx),
    .sum      (gx_out),
    .sum_next (gx_next)
  );

  mac_lane u_lane_y (
    .clk      (clk),
    .rst      (rst),
    .load     (first),
    .acc      (more),
    .clr      (flush),
    .pixel    (pixel_in),
    .coef     (cy),
    .sum      (gy_out),
    .sum_next (gy_next)
  );

  assign abs_x   = gx_next[ACC_W-1] ? -{1'b1, gx_next} : {1'b0, gx_next};
  assign abs_y   = gy_next[ACC_W-1] ? -{1'b1, gy_next} : {1'b0, gy_next};
  assign mag_sum = abs_x + abs_y;
  assign mag_sat = (|mag_sum[ACC_W:PIX_W]) ? {PIX_W{1'b1}} : mag_sum[PIX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      kx_l         <= '0;
      ky_l         <= '0;
      mag_out      <= '0;
      result_valid <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      mag_out      <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (first) begin
            state <= ACCUM;
            cnt   <= 4'd1;
            kx_l  <= kx;
            ky_l  <= ky;
          end
        end
        ACCUM: begin
          if (more) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd8) begin
              state        <= RESULT;
              result_valid <= 1'b1;
              mag_out      <= mag_sat;
            end
          end
        end
        RESULT: begin
          if (result_ready) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            result_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_gradient_convolver.sv
// ---------------------------------------------------------------------------
// tb_gradient_convolver: random and directed windows against a sum-of-products
// model, with a queue-based scoreboard consumed by an independent monitor.
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_gradient_convolver;
  import gradient_pkg::*;

  typedef struct {
    int gx;
    int gy;
    int mag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             pixel_valid;
  logic             pixel_ready;
  logic             result_valid;
  logic             result_ready;
  kernel_t          kx;
  kernel_t          ky;
  logic [PIX_W-1:0] pixel_in;
  logic [PIX_W-1:0] mag_out;
  logic [ACC_W-1:0] gx_out;
  logic [ACC_W-1:0] gy_out;

  exp_t exp_q[$];
  exp_t lit;
  bit   lit_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rr_mode = 1;

  always #5 clk = ~clk;

  gradient_convolver dut (
    .clk          (clk),
    .rst          (rst),
    .kx           (kx),
    .ky           (ky),
    .flush        (flush),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .gx_out       (gx_out),
    .gy_out       (gy_out),
    .mag_out      (mag_out),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Convolution straight from the definition: sum of pixel * coefficient
  function automatic exp_t model(input kernel_t a, input kernel_t b, input logic [7:0] p[9]);
    exp_t e;
    int   s;
    e.gx = 0;
    e.gy = 0;
    for (int k = 0; k < 9; k++) begin
      e.gx += int'(p[k]) * int'($signed(a[k/3][k%3]));
      e.gy += int'(p[k]) * int'($signed(b[k/3][k%3]));
    end
    s = (e.gx < 0 ? -e.gx : e.gx) + (e.gy < 0 ? -e.gy : e.gy);
    e.mag = (s > 255) ? 255 : s;
    return e;
  endfunction

  function automatic kernel_t rand_kernel();
    kernel_t k;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        k[r][c] = 5'($urandom_range(0, 31));
    return k;
  endfunction

  function automatic kernel_t kx_of(input int s);
    kernel_t k = '0;
    k[1][0] = 5'(s);
    k[1][2] = 5'(-s);
    return k;
  endfunction

  function automatic kernel_t ky_of(input int s);
    kernel_t k = '0;
    k[0][1] = 5'(s);
    k[2][1] = 5'(-s);
    return k;
  endfunction

  // result_ready driver: 0 random, 1 always high, 2 held low
  initial begin
    result_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       result_ready = ($urandom_range(0, 2) != 0);
        1:       result_ready = 1'b1;
        default: result_ready = 1'b0;
      endcase
    end
  end

  // Monitor: stability while stalled, handshake pops the scoreboard
  initial begin
    bit               hold;
    logic [ACC_W-1:0] hgx;
    logic [ACC_W-1:0] hgy;
    logic [PIX_W-1:0] hmag;
    exp_t             e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && result_valid) begin
        check("ready_low_in_result", int'(pixel_ready), 0);
        if (hold) begin
          check("hold_gx", int'(gx_out), int'(hgx));
          check("hold_gy", int'(gy_out), int'(hgy));
          check("hold_mag", int'(mag_out), int'(hmag));
        end
        if (result_ready && !flush) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("gx", $signed(gx_out), e.gx);
            check("gy", $signed(gy_out), e.gy);
            check("mag", int'(mag_out), e.mag);
          end
        end
      end
      hold = !rst && result_valid && !result_ready && !flush;
      hgx  = gx_out;
      hgy  = gy_out;
      hmag = mag_out;
    end
  end

  // Entered and left just after a rising edge
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("ready_while_rst", int'(pixel_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_gx", int'(gx_out), 0);
    check("rst_gy", int'(gy_out), 0);
    check("rst_mag", int'(mag_out), 0);
    check("rst_valid", int'(result_valid), 0);
    check("ready_while_rst2", int'(pixel_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pixel_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", int'(pixel_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_window(input kernel_t a, input kernel_t b, input logic [7:0] p[9],
                             input bit bubbles, input int chg_at, input int abort_at,
                             input bit abort_rst);
    exp_t e;
    int   k;
    int   budget;
    bit   rdy;
    bit   fl;
    e = model(a, b, p);
    if (lit_en) begin
      e = lit;
      lit_en = 1'b0;
    end
    kx = a;
    ky = b;
    k = 0;
    budget = 0;
    while (k < 9) begin
      budget++;
      if (budget > 300) begin
        check("window_timeout", k, 9);
        pixel_valid = 1'b0;
        return;
      end
      pixel_valid = (bubbles && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      pixel_in = p[k];
      if (k == chg_at) begin
        kx = rand_kernel();
        ky = rand_kernel();
      end
      if (k == abort_at && abort_rst) begin
        pixel_valid = 1'b1;
        do_reset();
        return;
      end
      fl = (k == abort_at) && pixel_valid;
      flush = fl;
      @(negedge clk);
      rdy = pixel_ready;
      if (k == 8 && pixel_valid && rdy)
        check("valid_before_last", int'(result_valid), 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (pixel_valid && rdy) begin
        if (fl) begin
          pixel_valid = 1'b0;
          @(negedge clk);
          check("flush_valid", int'(result_valid), 0);
          check("flush_gx", int'(gx_out), 0);
          check("flush_gy", int'(gy_out), 0);
          @(posedge clk);
          #1;
          return;
        end
        if (k == 8) exp_q.push_back(e);
        k++;
      end
    end
    pixel_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", int'(result_valid), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w[9];
    int         budget;

    rst = 1'b1;
    flush = 1'b0;
    pixel_valid = 1'b0;
    pixel_in = '0;
    kx = '0;
    ky = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed windows with hand-derived results
    lit = '{gx: 200, gy: 0, mag: 200};
    lit_en = 1'b1;
    w = '{8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0};
    send_window(kx_of(1), ky_of(1), w, 1'b0, -1, -1, 1'b0);

    lit = '{gx: 1785, gy: 1785, mag: 255};
    lit_en = 1'b1;
    w = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_window(kx_of(7), ky_of(7), w, 1'b0, -1, -1, 1'b0);

    lit = '{gx: -100, gy: 0, mag: 100};
    lit_en = 1'b1;
    w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd0, 8'd0, 8'd0};
    send_window(kx_of(1), ky_of(1), w, 1'b0, 4, -1, 1'b0);

    // Extreme windows: all-255 pixels against most-negative / most-positive kernels
    for (int k = 0; k < 9; k++) w[k] = 8'd255;
    send_window({9{5'b10000}}, {9{5'b01111}}, w, 1'b0, -1, -1, 1'b0);

    // Random windows with bubbles and random backpressure
    rr_mode = 0;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 9; k++) w[k] = 8'($urandom_range(0, 255));
      send_window(rand_kernel(), rand_kernel(), w, 1'b1, (n % 3 == 0) ? 3 : -1, -1, 1'b0);
    end

    // Result held for 5 cycles with result_ready low
    @(negedge clk);
    rr_mode = 2;
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) w[k] = 8'($urandom_range(0, 255));
    send_window(rand_kernel(), rand_kernel(), w, 1'b1, -1, -1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", int'(result_valid), 1);
      check("stall_ready", int'(pixel_ready), 0);
    end
    rr_mode = 1;
    @(posedge clk);
    #1;

    // Flush on the 5th accept, then a clean window
    for (int k = 0; k < 9; k++) w[k] = 8'($urandom_range(1, 255));
    send_window(rand_kernel(), rand_kernel(), w, 1'b0, -1, 4, 1'b0);
    send_window(rand_kernel(), rand_kernel(), w, 1'b1, -1, -1, 1'b0);

    // Flush colliding with the result handshake
    @(negedge clk);
    rr_mode = 2;
    @(posedge clk);
    #1;
    send_window(kx_of(3), ky_of(5), w, 1'b0, -1, -1, 1'b0);
    @(negedge clk);
    rr_mode = 1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_rr_valid", int'(result_valid), 0);
    check("flush_rr_gx", int'(gx_out), 0);
    check("flush_rr_mag", int'(mag_out), 0);
    @(posedge clk);
    #1;

    // Reset mid-ACCUM, then a full window
    send_window(rand_kernel(), rand_kernel(), w, 1'b0, -1, 4, 1'b1);
    send_window(rand_kernel(), rand_kernel(), w, 1'b1, -1, -1, 1'b0);

    // Reset while holding a result, then a full window
    @(negedge clk);
    rr_mode = 2;
    @(posedge clk);
    #1;
    send_window(kx_of(2), ky_of(-4), w, 1'b0, -1, -1, 1'b0);
    exp_q.delete();
    do_reset();
    @(negedge clk);
    rr_mode = 1;
    @(posedge clk);
    #1;
    send_window(rand_kernel(), rand_kernel(), w, 1'b1, -1, -1, 1'b0);

    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/gradient_convolver.md
# gradient_convolver

Streaming 3x3 convolution stage that sits directly downstream of `matrixgenerator`. It takes one 9-pixel window per operation, serialised one pixel per accepted beat. It multiply-accumulates the window against the X and Y kernels that `matrixgenerator` produces, then returns the signed gradients plus a saturated 8-bit edge magnitude through a valid/ready handshake.

## Interface
- `PIX_W`, 8, unsigned pixel width
- `COEF_W`, 5, signed kernel coefficient width (matches `matrixgenerator` outputs)
- `ACC_W`, 17, signed accumulator and gradient width
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `kx`  in  [2:0][2:0][COEF_W-1:0]  X kernel, indexed [row][col], two's complement; driven from `matrixgenerator.outx`
- `ky`  in  [2:0][2:0][COEF_W-1:0]  Y kernel, same format; driven from `matrixgenerator.outy`
- `flush`  in  1  synchronous abort of the current window
- `pixel_in`  in  PIX_W  window pixel, row-major order (index k → row k/3, col k%3)
- `pixel_valid`  in  1  pixel_in is valid
- `pixel_ready`  out  1  block accepts a pixel this cycle
- `gx_out`, `gy_out`  out  ACC_W  signed gradient results
- `mag_out`  out  PIX_W  min(255, |gx|+|gy|)
- `result_valid`  out  1  results valid
- `result_ready`  in  1  consumer takes the result

## Operation
- FSM states:
  - IDLE: waiting for pixel 0.
  - ACCUM: pixels 1..8.
  - RESULT: holding the output.
- Accept = `pixel_valid && pixel_ready`.
- IDLE → ACCUM on accept of pixel 0:
  - kernels latched into internal registers in the same cycle;
  - accumulators loaded with product 0, not added to stale values;
  - 4-bit index counter set to 1.
- ACCUM: each accept adds `pixel × kx_l[r][c]` and `pixel × ky_l[r][c]`, then increments the counter.
  - Accept of pixel 8 (counter == 8) → RESULT.
  - `pixel_valid` bubbles are allowed and leave all state unchanged.
- RESULT:
  - `result_valid` = 1 and `pixel_ready` = 0;
  - outputs are held stable until `result_ready`, then → IDLE.
- `pixel_ready` = 1 in IDLE and ACCUM, 0 in RESULT, and 0 whenever `rst` is high.
- Arithmetic:
  - pixel is zero-extended, coefficient is sign-extended;
  - each product fits in 13 bits signed (−4080..3825);
  - the 9-term sum fits in ACC_W = 17 without overflow, so no wrap is possible.
- Magnitude: |gx|+|gy| computed at 18 bits, then clamped to 255.
- Kernel inputs changing mid-window are ignored; only the latched copy is used.
- `flush` in any state: clears accumulators and counter, forces IDLE, drops `result_valid`.
  - `flush` with a simultaneous accept: flush wins and the pixel is discarded.
  - `flush` with a simultaneous `result_ready` in RESULT: flush wins; same end state either way.
- Reset values: state IDLE, counter 0, accumulators 0, `gx_out` = `gy_out` = 0, `mag_out` = 0, `result_valid` = 0.

## Timing
- Result latency: `result_valid` rises on the cycle after the edge that accepts pixel 8.
- `gx_out`, `gy_out` and `mag_out` are registered and valid in that same cycle.
- Minimum window period is 10 cycles: 9 accepts plus 1 RESULT cycle with `result_ready` = 1.
- Pixel 0 of the next window can be accepted on the cycle after the RESULT handshake.
- `rst` or `flush` asserted on edge N → IDLE and cleared outputs are visible after edge N.

## Structure
- Package `gradient_pkg` holds:
  - `PIX_W`, `COEF_W`, `ACC_W`;
  - `kernel_t` (packed [2:0][2:0][COEF_W-1:0]);
  - state enum `conv_state_t` {IDLE, ACCUM, RESULT}.
- Sub-module `mac_lane`, instantiated twice (X and Y):
  - sign-extending multiply plus load/accumulate/clear register;
  - control inputs `load`, `acc`, `clr`.
- Top level holds the FSM, the counter, the kernel latches, and the magnitude/saturation register.

## Test plan
- Kernel from bscalar = 1 (kx[1][0]=+1, kx[1][2]=−1, ky[0][1]=+1, ky[2][1]=−1, rest 0); window 200,0,0,200,0,0,200,0,0 → `gx_out` = 200, `gy_out` = 0, `mag_out` = 200, `result_valid` one cycle after the 9th accept.
- Kernel from bscalar = 7 (±7 in the same positions); window 0,255,0,255,0,0,0,0,0 → `gx_out` = 1785, `gy_out` = 1785, `mag_out` = 255 (saturated).
- Same bscalar = 1 kernel, pixel 5 = 100 and others 0 → `gx_out` = −100 (0x1FF9C), `mag_out` = 100; change `kx` at pixel 4 → result unchanged.
- Random `pixel_valid` bubbles, plus `result_ready` held low 5 cycles:
  - outputs stay stable and `pixel_ready` stays 0 throughout;
  - after release, the next window's first accept occurs no earlier than the following cycle.
- `flush` on the same cycle as the 5th accept → IDLE, no result produced; the following full window yields the correct fresh result.
- `rst` mid-ACCUM and again during RESULT → all outputs 0, `pixel_ready` 0 while `rst` is high and 1 the cycle after; a subsequent window computes correctly.
